// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment driver.
// Segment order is {a,b,c,d,e,f,g}, all active-LOW.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    // One digit slot as seen by the output stage after muxing.
    typedef struct packed {
        logic [3:0] nib;
        logic       blank;
        logic       dot;
    } digit_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam seg_t FONT_0 = 7'b0000001;
    localparam seg_t FONT_1 = 7'b1001111;
    localparam seg_t FONT_2 = 7'b0010010;
    localparam seg_t FONT_3 = 7'b0000110;
    localparam seg_t FONT_4 = 7'b1001100;
    localparam seg_t FONT_5 = 7'b0100100;
    localparam seg_t FONT_6 = 7'b0100000;
    localparam seg_t FONT_7 = 7'b0001111;
    localparam seg_t FONT_8 = 7'b0000000;
    localparam seg_t FONT_9 = 7'b0000100;
    localparam seg_t FONT_A = 7'b0001000;
    localparam seg_t FONT_B = 7'b1100000;
    localparam seg_t FONT_C = 7'b0110001;
    localparam seg_t FONT_D = 7'b1000010;
    localparam seg_t FONT_E = 7'b0110000;
    localparam seg_t FONT_F = 7'b0111000;

    // Packed table, FONT[n] is the glyph for nibble n.
    localparam logic [15:0][6:0] FONT = {
        FONT_F, FONT_E, FONT_D, FONT_C,
        FONT_B, FONT_A, FONT_9, FONT_8,
        FONT_7, FONT_6, FONT_5, FONT_4,
        FONT_3, FONT_2, FONT_1, FONT_0
    };

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Nibble to active-LOW 7-segment glyph with a blank override.
// Pure combinational; shared by all digits through the scan mux.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output seg_t       seg
);

    // Blank wins over the font lookup.
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            seg = FONT[nibble];
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver.
// Frame-synchronous image update, guard interval, LZ blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_suppress,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int IW = cnt_width(NUM_DIGITS);
    localparam int PW = cnt_width(REFRESH_DIV);

    localparam logic [PW-1:0] PHASE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD      = PW'(GUARD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0] phase;
    logic [IW-1:0] idx;
    logic          slot_end;
    logic          frame_end;
    logic          in_guard;

    logic [4*NUM_DIGITS-1:0] pend_data;
    logic [NUM_DIGITS-1:0]   pend_blank;
    logic [NUM_DIGITS-1:0]   pend_dp;

    logic [4*NUM_DIGITS-1:0] act_data;
    logic [NUM_DIGITS-1:0]   act_blank;
    logic [NUM_DIGITS-1:0]   act_dp;

    logic [NUM_DIGITS:0]     zero_from;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   eff_blank;

    digit_t                  cur;
    logic [NUM_DIGITS-1:0]   an_sel;
    seg_t                    font_seg;

    assign slot_end  = (phase == PHASE_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign in_guard  = (phase < GUARD);

    // Phase within a digit slot and the slot index; idx wraps at the frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
            idx   <= '0;
        end else if (slot_end) begin
            phase <= '0;
            if (frame_end) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end else begin
            phase <= phase + 1'b1;
        end
    end

    // Pending image: every load lands here, visible only after a commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_data  <= '0;
            pend_blank <= '1;
            pend_dp    <= '0;
        end else if (load) begin
            pend_data  <= digits_in;
            pend_blank <= blank_in;
            pend_dp    <= dp_in;
        end
    end

    // Active image swaps only at the frame wrap; a load on that cycle bypasses pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_data   <= '0;
            act_blank  <= '1;
            act_dp     <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (frame_end) begin
                if (load) begin
                    act_data  <= digits_in;
                    act_blank <= blank_in;
                    act_dp    <= dp_in;
                end else begin
                    act_data  <= pend_data;
                    act_blank <= pend_blank;
                    act_dp    <= pend_dp;
                end
            end
        end
    end

    // zero_from[k] is set when every active nibble from k upward is zero.
    always_comb begin
        zero_from             = '0;
        zero_from[NUM_DIGITS] = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_from[k] = zero_from[k+1]
                         && (act_data[4*k +: 4] == 4'd0);
        end
    end

    // Leading-zero mask never touches digit 0; blank is the OR of both sources.
    always_comb begin
        lz_mask    = zero_from[NUM_DIGITS-1:0];
        lz_mask[0] = 1'b0;
        eff_blank  = act_blank;
        if (lz_suppress) begin
            eff_blank = act_blank | lz_mask;
        end
    end

    // Select the current digit's data and its one-cold anode pattern.
    always_comb begin
        cur    = '0;
        an_sel = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur.nib   = act_data[4*k +: 4];
                cur.blank = eff_blank[k];
                cur.dot   = act_dp[k];
                an_sel[k] = 1'b0;
            end
        end
    end

    hex_to_seg7 u_font (
        .nibble (cur.nib),
        .blank  (cur.blank),
        .seg    (font_seg)
    );

    // Registered pins; the guard window keeps all anodes off while segments settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (in_guard) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_sel;
            seg <= font_seg;
            dp  <= ~cur.dot | cur.blank;
        end
    end

endmodule
